// File: rtl/sha256_cfu_responder.sv
// SHA-256 helper CFU: SUM0/SUM1/ADD plus optional SIG0/SIG1 (SHA256_CFU_SIGMA_EN),
// results queued in a small in-order response FIFO.
module sha256_cfu_responder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_function_id,
  input  logic [3:0]  req_id,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_id,
  output logic        resp_ok,
  output logic [7:0]  err_count
);

  localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        ok;
  } resp_t;

  resp_t          mem [FIFO_DEPTH];
  resp_t          res;
  resp_t          head;
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  logic [31:0]    a;
  logic [31:0]    sum0;
  logic [31:0]    sum1;
`ifdef SHA256_CFU_SIGMA_EN
  logic [31:0]    sig0;
  logic [31:0]    sig1;
`endif

  assign a    = req_data0;
  assign sum0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]}
              ^ {a[21:0], a[31:22]};
  assign sum1 = {a[5:0], a[31:6]} ^ {a[10:0], a[31:11]}
              ^ {a[24:0], a[31:25]};
`ifdef SHA256_CFU_SIGMA_EN
  assign sig0 = {a[6:0], a[31:7]} ^ {a[17:0], a[31:18]}
              ^ {3'b0, a[31:3]};
  assign sig1 = {a[16:0], a[31:17]} ^ {a[18:0], a[31:19]}
              ^ {10'b0, a[31:10]};
`endif

  always_comb begin
    res    = '0;
    res.id = req_id;
    case (req_function_id)
      3'd0: begin res.data = sum0; res.ok = 1'b1; end
      3'd1: begin res.data = sum1; res.ok = 1'b1; end
`ifdef SHA256_CFU_SIGMA_EN
      3'd2: begin res.data = sig0; res.ok = 1'b1; end
      3'd3: begin res.data = sig1; res.ok = 1'b1; end
`endif
      3'd4: begin
        res.data = req_data0 + req_data1;
        res.ok   = 1'b1;
      end
      default: begin
        res.data = '0;
        res.ok   = 1'b0;
      end
    endcase
  end

  // Ready depends only on occupancy (and reset), never on the handshakes.
  assign req_ready  = ~rst && (count < CW'(FIFO_DEPTH));
  assign resp_valid = (count != '0);
  assign push       = req_valid && req_ready;
  assign pop        = resp_valid && resp_ready;
  assign head       = mem[rptr];
  assign resp_data  = resp_valid ? head.data : '0;
  assign resp_id    = resp_valid ? head.id : '0;
  assign resp_ok    = resp_valid ? head.ok : 1'b0;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !res.ok && err_count != 8'hFF)
        err_count <= err_count + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while occupied.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= res;
  end

endmodule

// File: tb/tb_sha256_cfu_responder.sv
// Scoreboard bench for sha256_cfu_responder: random and directed requests
// checked against a rotate/shift reference model by a decoupled monitor.
module tb_sha256_cfu_responder;

  localparam int DEPTH = 2;
`ifdef SHA256_CFU_SIGMA_EN
  localparam bit SIGMA = 1'b1;
`else
  localparam bit SIGMA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_function_id = '0;
  logic [3:0]  req_id = '0;
  logic [31:0] req_data0 = '0;
  logic [31:0] req_data1 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [3:0]  resp_id;
  logic        resp_ok;
  logic [7:0]  err_count;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic        ok;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          model_err = 0;
  int          resp_mode = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_d;
  logic [3:0]  prev_i;
  logic        prev_o;

  sha256_cfu_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_function_id(req_function_id), .req_id(req_id),
    .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id),
    .resp_ok(resp_ok), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic exp_t model(input int fid, input logic [3:0] id,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id = id;
    e.ok = 1'b1;
    e.data = '0;
    case (fid)
      0: e.data = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      1: e.data = rotr(a, 6) ^ rotr(a, 11) ^ rotr(a, 25);
      2: if (SIGMA) e.data = rotr(a, 7) ^ rotr(a, 18) ^ (a >> 3);
         else e.ok = 1'b0;
      3: if (SIGMA) e.data = rotr(a, 17) ^ rotr(a, 19) ^ (a >> 10);
         else e.ok = 1'b0;
      4: e.data = a + b;
      default: e.ok = 1'b0;
    endcase
    if (!e.ok) e.data = '0;
    return e;
  endfunction

  task automatic send_exp(input int fid, input logic [3:0] id,
                          input logic [31:0] a, input logic [31:0] b,
                          input exp_t e);
    int w = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_function_id = 3'(fid);
    req_id = id;
    req_data0 = a;
    req_data1 = b;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready %b want 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(e);
    if (!e.ok && model_err < 255) model_err++;
    #1 req_valid = 1'b0;
  endtask

  task automatic send(input int fid, input logic [3:0] id,
                      input logic [31:0] a, input logic [31:0] b);
    send_exp(fid, id, a, b, model(fid, id, a, b));
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (resp_mode)
        1: resp_ready = 1'b1;
        2: resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every completed response handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (resp_valid) begin
        if (prev_v && !prev_r)
          chk("hold_stable", {resp_data ^ prev_d, 3'b0, resp_ok ^ prev_o},
              {28'd0, prev_i ^ resp_id});
        if (resp_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_resp", 32'd1, 32'd0);
          end else begin
            m_e = exp_q.pop_front();
            chk("resp_data", resp_data, m_e.data);
            chk("resp_id", 32'(resp_id), 32'(m_e.id));
            chk("resp_ok", 32'(resp_ok), 32'(m_e.ok));
          end
        end
      end else begin
        chk("idle_zero", {resp_data[31:5], resp_id, resp_ok},
            32'd0);
        chk("idle_data_lo", 32'(resp_data[4:0]), 32'd0);
      end
      prev_v = resp_valid;
      prev_r = resp_ready;
      prev_d = resp_data;
      prev_i = resp_id;
      prev_o = resp_ok;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t want completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int fid;
    logic [31:0] a;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("ready_after_rst", 32'(req_ready), 32'd1);
    resp_mode = 1;

    e.data = 32'hCE20B47E; e.id = 4'h5; e.ok = 1'b1;
    send_exp(0, 4'h5, 32'h6A09E667, 32'h0, e);
    @(negedge clk);
    chk("latency_1", 32'(resp_valid), 32'd1);
    e.data = 32'h00000001; e.id = 4'h9; e.ok = 1'b1;
    send_exp(4, 4'h9, 32'hFFFFFFFF, 32'h00000002, e);
    drain();

    resp_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++)
      send(i % 2, 4'(i + 1), $urandom, $urandom);
    @(negedge clk);
    chk("full_ready", 32'(req_ready), 32'd0);
    resp_mode = 1;
    send(4, 4'hC, 32'h80000000, 32'h80000001);
    drain();

    resp_mode = 2;
    for (int i = 0; i < 200; i++) begin
      fid = $urandom_range(0, 7);
      a = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom;
      send(fid, 4'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    resp_mode = 1;
    drain();
    chk("err_after_rand", 32'(err_count), 32'(model_err));

    resp_mode = 0;
    send(0, 4'h1, $urandom, 32'h0);
    send(1, 4'h2, $urandom, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_data", resp_data, 32'd0);
    exp_q.delete();
    model_err = 0;
    @(negedge clk);
    chk("midrst_err", 32'(err_count), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    resp_mode = 1;
    #1 chk("ready_after_midrst", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("no_stale", 32'(resp_valid), 32'd0);

    send(2, 4'h7, 32'h12345678, 32'h0);
    drain();
    chk("err_sig0", 32'(err_count), 32'(model_err));

    for (int i = 0; i < 260; i++)
      send(6, 4'(i), $urandom, $urandom);
    drain();
    chk("err_sat_model", 32'(err_count), 32'(model_err));
    chk("err_sat_255", 32'(err_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
